// File: rtl/usb_tx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usb_tx_pkg : shared types and constants for the USB TX sequencer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package usb_tx_pkg;

  localparam int unsigned MAX_BYTES_DEFAULT = 64;

  // Sent LSB-first, this produces the USB SYNC field 0000_0001.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PID  = 3'd2,
    ST_DATA = 3'd3,
    ST_END  = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_tx_sequencer_shift_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_shift_reg : 8-bit loadable LSB-first shifter with bit counter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tx_shift_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic       last_bit_o
);

  logic [7:0] sr_q;
  logic [2:0] cnt_q;

  // A load coinciding with the shift of bit 7 wins and restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {1'b0, sr_q[7:1]};
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign bit_o      = sr_q[0];
  assign last_bit_o = (cnt_q == 3'd7);

endmodule
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usb_tx_sequencer : serializes SYNC, PID and payload into bit_stuff|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter  int MAX_BYTES = MAX_BYTES_DEFAULT,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [7:0]       req_pid_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             ack_o,
  input  logic [7:0]       byte_in_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             bs_start_o,
  output logic             bs_bit_o,
  output logic             bs_endb_o,
  input  logic             bs_pause_i,
  input  logic             bs_done_i,
  output logic             busy_o,
  output logic             underrun_o
);

  tx_state_t        state_q;
  logic [7:0]       pid_q;
  logic [LEN_W-1:0] remain_q;
  logic [LEN_W-1:0] remain_d;
  logic [LEN_W-1:0] len_clamped;
  logic             start;
  logic             in_bits;
  logic             consume;
  logic             boundary;
  logic             more_bytes;
  logic             take;
  logic             sr_load;
  logic [7:0]       sr_load_data;
  logic             sr_bit;
  logic             sr_last;

  assign start       = (state_q == ST_IDLE) & req_i;
  assign in_bits     = (state_q == ST_SYNC) | (state_q == ST_PID) | (state_q == ST_DATA);
  assign consume     = in_bits & ~bs_pause_i;
  assign boundary    = consume & sr_last;
  assign more_bytes  = (remain_q != '0);
  assign len_clamped = (req_len_i > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : req_len_i;

  // Handshake strobes are combinational: the stuffer consumes a bit per
  // unpaused cycle, so the next byte must be accepted in the same cycle.
  assign byte_ready_o = boundary & more_bytes & ((state_q == ST_PID) | (state_q == ST_DATA));
  assign take         = byte_ready_o & byte_valid_i;
  assign underrun_o   = byte_ready_o & ~byte_valid_i;

  assign sr_load = start | ((state_q == ST_SYNC) & boundary) | take;

  always_comb begin
    sr_load_data = byte_in_i;
    if (start) begin
      sr_load_data = SYNC_PATTERN;
    end else if (state_q == ST_SYNC) begin
      sr_load_data = pid_q;
    end
  end

  tx_shift_reg u_shift (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sr_load),
    .load_data_i (sr_load_data),
    .shift_i     (consume),
    .bit_o       (sr_bit),
    .last_bit_o  (sr_last)
  );

  // Bytes still to be loaded after the one currently shifting out.
  always_comb begin
    remain_d = remain_q;
    if (start) begin
      remain_d = len_clamped;
    end else if (take) begin
      remain_d = remain_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= '0;
    end else begin
      remain_q <= remain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pid_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            state_q <= ST_SYNC;
            pid_q   <= req_pid_i;
          end
        end
        ST_SYNC: begin
          if (boundary) state_q <= ST_PID;
        end
        ST_PID, ST_DATA: begin
          if (boundary) begin
            if (take) state_q <= ST_DATA;
            else      state_q <= ST_END;
          end
        end
        ST_END: begin
          if (bs_done_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_o      = start;
  assign bs_start_o = start;
  assign bs_bit_o   = in_bits & sr_bit;
  assign bs_endb_o  = (state_q == ST_END);
  assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_usb_tx_sequencer : directed + randomized bench for the TX seq |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_usb_tx_sequencer;

  localparam int MAXB = 64;
  localparam int LW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [7:0]    req_pid;
  logic [LW-1:0] req_len;
  logic          ack;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          bs_start;
  logic          bs_bit;
  logic          bs_endb;
  logic          bs_pause;
  logic          bs_done;
  logic          busy;
  logic          underrun;
  logic          done_ok;

  // Stuffer answers end-of-bits combinationally once its tail is flushed.
  assign bs_done = bs_endb & done_ok;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.MAX_BYTES(MAXB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .req_pid_i    (req_pid),
    .req_len_i    (req_len),
    .ack_o        (ack),
    .byte_in_i    (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .bs_start_o   (bs_start),
    .bs_bit_o     (bs_bit),
    .bs_endb_o    (bs_endb),
    .bs_pause_i   (bs_pause),
    .bs_done_i    (bs_done),
    .busy_o       (busy),
    .underrun_o   (underrun)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [0:79];

  int endb_c, idle_c, npause, br_c0, br_c1, un_c, taken;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pmode: 0 no pauses, 1 bit-stuff pauses, 2 bit-stuff plus random pauses.
  task automatic run_packet(input logic [7:0] pid, input int len, input int drop,
                            input int pmode, input int ddelay, input int rst_at,
                            input bit hold_req);
    int   c, nbits, ones, dcnt, L, nb, bitmis, viol, nacks, nun, nbr, ack2_c;
    bit   active, pend_next, pbit_v, finished, exp_un, ack0;
    logic pbit;
    logic expq[$];
    logic gotq[$];

    L      = (len > MAXB) ? MAXB : len;
    nb     = (drop < L) ? drop : L;
    exp_un = (drop < L);
    expq   = {};
    gotq   = {};
    for (int i = 0; i < 8; i++) expq.push_back(i == 7);
    for (int i = 0; i < 8; i++) expq.push_back(pid[i]);
    for (int k = 0; k < nb; k++)
      for (int i = 0; i < 8; i++) expq.push_back(pay[k][i]);

    endb_c = -1; idle_c = -1; npause = 0; br_c0 = -1; br_c1 = -1; un_c = -1; taken = 0;
    nbits = 0; ones = 0; dcnt = 0; viol = 0; nacks = 0; nun = 0; nbr = 0; ack2_c = -1;
    active = 0; pbit_v = 0; pbit = 1'b0; finished = 0; ack0 = 0;

    req        = 1'b1;
    req_pid    = pid;
    req_len    = LW'(len);
    byte_in    = pay[0];
    byte_valid = (drop != 0);
    bs_pause   = 1'b0;
    done_ok    = (ddelay == 0);

    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      pend_next = 0;
      if (ack !== bs_start) viol++;
      if (ack) begin
        nacks++;
        if (c == 0) ack0 = 1;
        else if (ack2_c < 0) ack2_c = c;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("reset_mid_packet_outputs",
            {ack, byte_ready, bs_start, bs_bit, bs_endb, busy, underrun}, 0);
        finished = 1;
        break;
      end
      if (byte_ready && bs_pause) viol++;
      if (byte_ready) begin
        nbr++;
        if (br_c0 < 0) br_c0 = c;
        else if (br_c1 < 0) br_c1 = c;
      end
      if (underrun) begin
        nun++;
        un_c = c;
      end
      if (byte_ready && byte_valid) taken++;

      if (bs_start && c == 0) begin
        active = 1; nbits = 0; ones = 0;
      end else if (active && !bs_endb) begin
        if (bs_pause) begin
          npause++;
          pbit   = bs_bit;
          pbit_v = 1;
        end else begin
          if (pbit_v && bs_bit !== pbit) viol++;
          pbit_v = 0;
          gotq.push_back(bs_bit);
          nbits++;
          if (nbits > 16 && pmode != 0) begin
            ones = bs_bit ? ones + 1 : 0;
            if (ones == 6) begin
              pend_next = 1;
              ones      = 0;
            end
          end
        end
      end
      if (bs_endb) begin
        if (bs_bit !== 1'b0) viol++;
        if (endb_c < 0) endb_c = c;
        active = 0;
        dcnt++;
      end
      if (!busy && c > 0) begin
        idle_c   = c;
        finished = 1;
        break;
      end

      @(posedge clk);
      #1;
      if (!hold_req) req = 1'b0;
      rst        = (rst_at >= 0 && c + 1 == rst_at);
      byte_in    = pay[taken];
      byte_valid = (taken != drop);
      bs_pause   = pend_next | (pmode == 2 && active && $urandom_range(0, 3) == 0);
      done_ok    = (dcnt >= ddelay);
    end

    chk("packet_timeout", finished, 1);
    if (rst_at < 0) begin
      chk("ack_in_cycle0", ack0, 1);
      chk("bit_count", gotq.size(), expq.size());
      bitmis = 0;
      for (int i = 0; i < gotq.size() && i < expq.size(); i++)
        if (gotq[i] !== expq[i]) bitmis++;
      chk("bit_mismatches", bitmis, 0);
      chk("bytes_taken", taken, nb);
      chk("underrun_pulses", nun, exp_un);
      chk("byte_ready_pulses", nbr, nb + int'(exp_un));
      chk("endb_cycle", endb_c, 17 + 8 * nb + npause);
      chk("idle_cycle", idle_c, 18 + 8 * nb + npause + ddelay);
      chk("protocol_violations", viol, 0);
      chk("ack_count", nacks, hold_req ? 2 : 1);
      if (hold_req) chk("second_ack_cycle", ack2_c, idle_c);
    end

    @(posedge clk);
    #1;
    req      = 1'b0;
    rst      = 1'b0;
    bs_pause = 1'b0;
  endtask

  initial begin
    int len, drop;
    rst        = 1'b1;
    req        = 1'b0;
    req_pid    = '0;
    req_len    = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    bs_pause   = 1'b0;
    done_ok    = 1'b1;
    for (int i = 0; i < 80; i++) pay[i] = 8'($urandom);

    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_state_outputs",
        {ack, byte_ready, bs_start, bs_bit, bs_endb, busy, underrun}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset_outputs",
        {ack, byte_ready, bs_start, bs_bit, bs_endb, busy, underrun}, 0);
    @(posedge clk); #1;

    // Empty packet: SYNC + PID only.
    run_packet(8'hC3, 0, 1000, 0, 0, -1, 0);
    chk("len0_endb_cycle", endb_c, 17);
    chk("len0_idle_cycle", idle_c, 18);

    // Two bytes, no pauses.
    pay[0] = 8'hA5; pay[1] = 8'h5A;
    run_packet(8'h4B, 2, 1000, 0, 0, -1, 0);
    chk("len2_byte_ready_first", br_c0, 16);
    chk("len2_byte_ready_second", br_c1, 24);
    chk("len2_endb_cycle", endb_c, 33);

    // All-ones payload forces two stuff pauses.
    pay[0] = 8'hFF; pay[1] = 8'hFF;
    run_packet(8'hC3, 2, 1000, 1, 0, -1, 0);
    chk("stuff_pause_count", npause, 2);
    chk("stuff_endb_cycle", endb_c, 35);

    // Source runs dry at the second byte boundary.
    pay[0] = 8'h3C; pay[1] = 8'h99; pay[2] = 8'h01;
    run_packet(8'h4B, 3, 1, 0, 0, -1, 0);
    chk("underrun_cycle", un_c, 24);
    chk("underrun_endb_cycle", endb_c, 25);
    chk("underrun_bytes_taken", taken, 1);

    // Reset in the middle of a packet, then an immediate new request.
    run_packet(8'hC3, 4, 1000, 0, 0, 20, 0);
    run_packet(8'hD2, 1, 1000, 0, 1, -1, 0);

    // Oversized length with req held through END.
    for (int i = 0; i < 80; i++) pay[i] = 8'($urandom);
    run_packet(8'h87, MAXB + 5, 1000, 2, 2, -1, 1);
    chk("clamped_bytes_taken", taken, MAXB);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 80; i++) pay[i] = 8'($urandom);
      len  = $urandom_range(0, 70);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : 1000;
      run_packet(8'($urandom), len, drop, $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Packet-level transmit controller that feeds the bit-stuffing stage of the USB transmit path. It accepts one packet request (PID plus payload length) and serializes SYNC, PID and payload bytes LSB-first onto the stuffer's serial input. It starts the stuffer, honours its stuff-insertion pauses, and terminates the packet with end-of-bits. It sits between the packet builder (token/data/handshake generators, payload FIFO with CRC already appended) and `bit_stuff` → NRZI.

## Interface
- `MAX_BYTES`, 64: largest payload in bytes, including CRC bytes supplied upstream.
- `LEN_W`, `$clog2(MAX_BYTES+1)`: width of the length field. Derived; do not override.

- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  packet request; held high by the requester until `ack`.
- `req_pid`  in  8  PID byte, already containing its check nibble.
- `req_len`  in  LEN_W  payload byte count, 0..MAX_BYTES.
- `ack`  out  1  one-cycle pulse when the request is latched.
- `byte_in`  in  8  payload byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  sequencer takes `byte_in` this cycle.
- `bs_start`  out  1  to stuffer `start`.
- `bs_bit`  out  1  to stuffer `s_in`.
- `bs_endb`  out  1  to stuffer `endb`.
- `bs_pause`  in  1  stuffer is inserting a zero; the current bit is not consumed.
- `bs_done`  in  1  stuffer has finished the packet.
- `busy`  out  1  high in every state except IDLE.
- `underrun`  out  1  one-cycle pulse when the payload source was not ready and the packet was aborted.

## Operation
- States: IDLE, SYNC, PID, DATA, END.
- **IDLE**
  - On `req`: pulse `ack` and `bs_start` in the same cycle.
  - Latch `req_pid` and `req_len` (clamped to MAX_BYTES).
  - Load the shift register with SYNC_PATTERN 8'b1000_0000, so the LSB-first stream is 0000_0001.
  - Next state: SYNC.
- **Bit consumption.** In SYNC, PID or DATA, a bit is consumed in every cycle where `bs_pause`=0. On consumption, shift right and increment the 3-bit bit counter. When `bs_pause`=1, hold the shift register, bit counter and `bs_bit`.
- **`bs_bit`** always equals shift register bit 0 in SYNC/PID/DATA, and is 0 elsewhere.
- **SYNC** → PID when bit 7 is consumed. Load `req_pid`.
- **PID** → on bit 7 consumption:
  - If len=0: go to END.
  - Otherwise: go to DATA. `byte_ready`=1 that cycle.
- **DATA**
  - `byte_ready`=1 only in the cycle bit 7 of the current byte is consumed and bytes remain. This includes the PID→DATA boundary.
  - If `byte_valid`=1: load `byte_in` and decrement the remaining count.
  - If `byte_valid`=0: pulse `underrun` and go to END. Payload is truncated; no retry.
  - When the last byte's bit 7 is consumed → END.
- **END**
  - Assert `bs_endb` and hold it until `bs_done`.
  - On `bs_done` → IDLE in the next cycle.
  - `busy` drops in IDLE.
- **No streaming of requests.** `req` is ignored outside IDLE.
- **Simultaneous events.**
  - `bs_pause` at a byte boundary: `byte_ready` is not asserted, and the boundary is re-evaluated in the next unpaused cycle.
  - `req` arriving in the same cycle END→IDLE occurs: it is seen one cycle later.
- **Reset mid-packet.**
  - The sequencer returns to IDLE.
  - Every output is 0 in the cycle after `rst` is sampled high.
  - The integration must reset the stuffer in the same cycle.
- **Reset values:** `ack`, `byte_ready`, `bs_start`, `bs_bit`, `bs_endb`, `busy`, `underrun` are all 0.

## Timing
- `ack`/`bs_start` in cycle 0; the first SYNC bit is consumed in cycle 1.
- SYNC+PID occupy exactly 16 unpaused cycles. These match the stuffer's unstuffed preamble window.
- With no pauses, the last payload bit is consumed in cycle 16+8·len, and `bs_endb` is first asserted in cycle 17+8·len.
- Each `bs_pause` cycle adds one cycle.
- `byte_ready` is combinational from state, bit counter and `bs_pause`. It has no dependence on `byte_valid`.

## Structure
- Package `usb_tx_pkg` holds:
  - the state enum `tx_state_t`;
  - the `SYNC_PATTERN` constant;
  - the default `MAX_BYTES`.
- Sub-module `tx_shift_reg`: 8-bit loadable LSB-first shift register with a 3-bit bit counter and `last_bit` flag, with load/shift/hold controls.
- The remaining-byte count uses the shared `counter` module or a local down-counter.

## Test plan
- pid=8'hC3, len=0, no pauses:
  - `bs_bit` sequence is 0000_0001 then 1100_0011.
  - `bs_endb` at cycle 17; `busy` low at cycle 18.
- len=2, bytes 8'hA5 and 8'h5A, valid always, bench stuffer model with no pauses:
  - `byte_ready` pulses at cycles 16 and 24.
  - `bs_endb` at cycle 33.
- len=2, bytes 8'hFF and 8'hFF, real `bit_stuff` instantiated:
  - exactly 2 pause cycles occur, during which `bs_bit` holds;
  - `bs_endb` at cycle 35.
- len=3, `byte_valid` dropped at the second boundary (cycle 24):
  - `underrun` pulses at cycle 24;
  - `bs_endb` at cycle 25;
  - only one payload byte is consumed.
- `rst` asserted at cycle 20 of a len=4 packet:
  - all outputs are 0 at cycle 21;
  - a new `req` at cycle 22 gives `ack` at cycle 22.
- `req` held during END:
  - no second `ack` until the cycle after IDLE is entered;
  - `req_len`=MAX_BYTES+5 is clamped to MAX_BYTES bytes.
